// File: rtl/json_motion_formatter_pkg.sv
// Shared constants and state type for the JSON motion command formatter.
package json_cmd_pkg;

    localparam logic [7:0] ASC_LBRACE = 8'h7B;
    localparam logic [7:0] ASC_RBRACE = 8'h7D;
    localparam logic [7:0] ASC_QUOTE  = 8'h22;
    localparam logic [7:0] ASC_COLON  = 8'h3A;
    localparam logic [7:0] ASC_COMMA  = 8'h2C;
    localparam logic [7:0] ASC_DOT    = 8'h2E;
    localparam logic [7:0] ASC_MINUS  = 8'h2D;
    localparam logic [7:0] ASC_T      = 8'h54;
    localparam logic [7:0] ASC_L      = 8'h4C;
    localparam logic [7:0] ASC_R      = 8'h52;
    localparam logic [7:0] ASC_LF     = 8'h0A;
    localparam logic [7:0] ASC_ZERO   = 8'h30;

    localparam int FRAME_MAX_BYTES = 28;

    typedef enum logic [1:0] {IDLE, CONV_L, CONV_R, EMIT} fmt_state_t;

    function automatic logic [7:0] bcd_ascii(input logic [3:0] d);
        return ASC_ZERO + {4'h0, d};
    endfunction

endpackage

// File: rtl/json_motion_formatter_digits.sv
// Sequential decimal splitter: magnitude 0..999 into integer, tens and units digits.
module dec_digit_extractor (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic [9:0] i_mag,
    output logic       o_done,
    output logic [3:0] o_int,
    output logic [3:0] o_tens,
    output logic [3:0] o_units
);

    logic [9:0] r_rem;
    logic       r_busy;
    logic       r_done;
    logic [3:0] r_int;
    logic [3:0] r_tens;
    logic [3:0] r_units;

    // Hundreds steps, then tens steps, then one finishing cycle: at most 9+9+1 cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rem   <= 10'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_int   <= 4'd0;
            r_tens  <= 4'd0;
            r_units <= 4'd0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_rem  <= i_mag;
                r_int  <= 4'd0;
                r_tens <= 4'd0;
                r_busy <= 1'b1;
            end else if (r_busy) begin
                if (r_rem >= 10'd100) begin
                    r_rem <= r_rem - 10'd100;
                    r_int <= r_int + 4'd1;
                end else if (r_rem >= 10'd10) begin
                    r_rem  <= r_rem - 10'd10;
                    r_tens <= r_tens + 4'd1;
                end else begin
                    r_units <= r_rem[3:0];
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
            end
        end
    end

    assign o_done  = r_done;
    assign o_int   = r_int;
    assign o_tens  = r_tens;
    assign o_units = r_units;

endmodule

// File: rtl/json_motion_formatter.sv
// Formats a clamped left/right speed pair as {"T":t,"L":[-]i.tu,"R":[-]i.tu} on a byte stream.
// Build option JSON_NEWLINE_EN appends a line feed that carries the last-byte flag.
module json_motion_formatter
    import json_cmd_pkg::*;
#(
    parameter int SPEED_W = 9,
    parameter int MAX_MAG = 100,
    parameter int T_CODE  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_cmd_valid,
    output logic                      o_cmd_ready,
    input  logic signed [SPEED_W-1:0] i_left_speed,
    input  logic signed [SPEED_W-1:0] i_right_speed,
    output logic                      o_out_valid,
    input  logic                      i_out_ready,
    output logic [7:0]                o_out_data,
    output logic                      o_out_last,
    output fmt_state_t                o_dbg_state
);

    localparam int EW = (SPEED_W > 11) ? SPEED_W + 1 : 12;
    localparam logic [4:0] POS_SIGN_L = 5'd11;
    localparam logic [4:0] POS_SIGN_R = 5'd21;
`ifdef JSON_NEWLINE_EN
    localparam logic [4:0] POS_LAST = 5'd27;
`else
    localparam logic [4:0] POS_LAST = 5'd26;
`endif

    fmt_state_t r_state, w_next;
    logic       w_start;
    logic [9:0] w_clamp_l, w_clamp_r, w_ext_mag;
    logic       w_ext_done;
    logic [3:0] w_ext_int, w_ext_tens, w_ext_units;
    logic       r_sign_l, r_sign_r;
    logic [9:0] r_mag_r;
    logic [3:0] r_l_i, r_l_t, r_l_u, r_r_i, r_r_t, r_r_u;
    logic [4:0] r_pos, w_pos_inc, w_next_pos;
    logic [7:0] w_next_byte;
    logic       r_out_valid, r_out_last;
    logic [7:0] r_out_data;

    function automatic logic [9:0] clamp_mag(input logic signed [SPEED_W-1:0] v);
        logic signed [EW-1:0] x;
        logic signed [EW-1:0] lim;
        x   = EW'(v);
        lim = EW'(MAX_MAG);
        if (x > lim || x < -lim) return 10'(MAX_MAG);
        else if (x[EW-1])        return 10'(-x);
        else                     return 10'(x);
    endfunction

    assign w_clamp_l = clamp_mag(i_left_speed);
    assign w_clamp_r = clamp_mag(i_right_speed);
    assign w_ext_mag = (r_state == IDLE) ? w_clamp_l : r_mag_r;

    dec_digit_extractor u_digits (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_start),
        .i_mag   (w_ext_mag),
        .o_done  (w_ext_done),
        .o_int   (w_ext_int),
        .o_tens  (w_ext_tens),
        .o_units (w_ext_units)
    );

    always_ff @(posedge clk) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        o_cmd_ready = 1'b0;
        w_start     = 1'b0;
        case (r_state)
            IDLE: begin
                o_cmd_ready = 1'b1;
                if (i_cmd_valid) begin
                    w_next  = CONV_L;
                    w_start = 1'b1;
                end
            end
            CONV_L: if (w_ext_done) begin
                w_next  = CONV_R;
                w_start = 1'b1;
            end
            CONV_R: if (w_ext_done) w_next = EMIT;
            EMIT:   if (r_out_valid && i_out_ready && r_out_last) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Template positions 11 and 21 are the sign slots; a positive or zero value skips them.
    always_comb begin
        w_pos_inc  = r_pos + 5'd1;
        w_next_pos = w_pos_inc;
        if ((w_pos_inc == POS_SIGN_L && !r_sign_l) || (w_pos_inc == POS_SIGN_R && !r_sign_r))
            w_next_pos = w_pos_inc + 5'd1;
    end

    always_comb begin
        w_next_byte = 8'h00;
        case (w_next_pos)
            5'd0:  w_next_byte = ASC_LBRACE;
            5'd1, 5'd3, 5'd7, 5'd9, 5'd17, 5'd19: w_next_byte = ASC_QUOTE;
            5'd2:  w_next_byte = ASC_T;
            5'd4, 5'd10, 5'd20: w_next_byte = ASC_COLON;
            5'd5:  w_next_byte = ASC_ZERO + 8'(T_CODE);
            5'd6, 5'd16: w_next_byte = ASC_COMMA;
            5'd8:  w_next_byte = ASC_L;
            5'd11, 5'd21: w_next_byte = ASC_MINUS;
            5'd12: w_next_byte = bcd_ascii(r_l_i);
            5'd13, 5'd23: w_next_byte = ASC_DOT;
            5'd14: w_next_byte = bcd_ascii(r_l_t);
            5'd15: w_next_byte = bcd_ascii(r_l_u);
            5'd18: w_next_byte = ASC_R;
            5'd22: w_next_byte = bcd_ascii(r_r_i);
            5'd24: w_next_byte = bcd_ascii(r_r_t);
            5'd25: w_next_byte = bcd_ascii(r_r_u);
            5'd26: w_next_byte = ASC_RBRACE;
            5'd27: w_next_byte = ASC_LF;
            default: w_next_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sign_l    <= 1'b0;
            r_sign_r    <= 1'b0;
            r_mag_r     <= 10'd0;
            r_l_i       <= 4'd0;
            r_l_t       <= 4'd0;
            r_l_u       <= 4'd0;
            r_r_i       <= 4'd0;
            r_r_t       <= 4'd0;
            r_r_u       <= 4'd0;
            r_pos       <= 5'd0;
            r_out_valid <= 1'b0;
            r_out_data  <= 8'h00;
            r_out_last  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (i_cmd_valid) begin
                    r_sign_l <= i_left_speed[SPEED_W-1];
                    r_sign_r <= i_right_speed[SPEED_W-1];
                    r_mag_r  <= w_clamp_r;
                end
                CONV_L: if (w_ext_done) begin
                    r_l_i <= w_ext_int;
                    r_l_t <= w_ext_tens;
                    r_l_u <= w_ext_units;
                end
                CONV_R: if (w_ext_done) begin
                    r_r_i       <= w_ext_int;
                    r_r_t       <= w_ext_tens;
                    r_r_u       <= w_ext_units;
                    r_pos       <= 5'd0;
                    r_out_valid <= 1'b1;
                    r_out_data  <= ASC_LBRACE;
                    r_out_last  <= 1'b0;
                end
                EMIT: if (r_out_valid && i_out_ready) begin
                    if (r_out_last) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        r_out_data  <= 8'h00;
                    end else begin
                        r_pos      <= w_next_pos;
                        r_out_data <= w_next_byte;
                        r_out_last <= (w_next_pos == POS_LAST);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_last  = r_out_last;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_json_motion_formatter.sv
// Scoreboard bench for json_motion_formatter: expected frames queued at command time, checked by a monitor.
module tb_json_motion_formatter;
    import json_cmd_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic signed [8:0] left = 9'sd0;
    logic signed [8:0] right = 9'sd0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [7:0]        out_data;
    logic              out_last;
    fmt_state_t        dbg_state;

    logic [8:0] exp_q[$];
    int         n_vec = 0;
    int         n_bad = 0;
    int         rx_cnt = 0;
    int         stall_cnt = 0;
    logic       bp_mode = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_last = 1'b0;

    always #10 clk = ~clk;

    json_motion_formatter dut (
        .clk           (clk),
        .rst           (rst),
        .i_cmd_valid   (cmd_valid),
        .o_cmd_ready   (cmd_ready),
        .i_left_speed  (left),
        .i_right_speed (right),
        .o_out_valid   (out_valid),
        .i_out_ready   (out_ready),
        .o_out_data    (out_data),
        .o_out_last    (out_last),
        .o_dbg_state   (dbg_state)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    task automatic push_str(input string s);
        logic lst;
        for (int i = 0; i < s.len(); i++) begin
`ifdef JSON_NEWLINE_EN
            lst = 1'b0;
`else
            lst = (i == s.len() - 1);
`endif
            exp_q.push_back({lst, s[i]});
        end
`ifdef JSON_NEWLINE_EN
        exp_q.push_back({1'b1, 8'h0A});
`endif
    endtask

    task automatic send_cmd(input int l, input int r, input string s);
        int  n;
        logic ok;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 300) begin
            @(posedge clk); #1;
            if (cmd_ready) ok = 1'b1;
            n++;
        end
        chk("cmd_ready_wait", 32'(ok), 32'd1);
        if (ok) begin
            left      = 9'(l);
            right     = 9'(r);
            cmd_valid = 1'b1;
            push_str(s);
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            n = 0;
            while (!out_valid && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
            chk("first_byte_within_40", 32'(out_valid && n <= 40), 32'd1);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && cmd_ready && !out_valid) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk("frame_complete", 32'(exp_q.size() == 0 && cmd_ready && !out_valid), 32'd1);
    endtask

    always @(negedge clk) begin
        logic [8:0] e;
        if (!rst) begin
            prev_stall = 1'b0;
            rx_cnt     = 0;
        end else begin
            if (prev_stall) begin
                n_vec++;
                if (!out_valid || out_data !== prev_data || out_last !== prev_last) begin
                    n_bad++;
                    $display("FAIL stall_hold: valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                             out_valid, out_data, out_last, prev_data, prev_last);
                end
            end
            if (out_valid && out_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_byte: got data=%h last=%b, required no byte", out_data, out_last);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_last, out_data} !== e) begin
                        n_bad++;
                        $display("FAIL byte%0d: got data=%h last=%b, required data=%h last=%b",
                                 rx_cnt, out_data, out_last, e[7:0], e[8]);
                    end
                end
                rx_cnt = out_last ? 0 : rx_cnt + 1;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    // Backpressure: alternate ready each cycle, with a 20-cycle hold on frame byte 10.
    always @(posedge clk) begin
        #1;
        if (!bp_mode) out_ready = 1'b1;
        else if (rx_cnt == 10 && stall_cnt < 20) begin
            out_ready = 1'b0;
            stall_cnt++;
        end else out_ready = ~out_ready;
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'h00);
        @(posedge clk); #1;
        rst = 1'b1;

        send_cmd(50, 50, "{\"T\":1,\"L\":0.50,\"R\":0.50}");
        wait_idle(200);
        send_cmd(-25, 100, "{\"T\":1,\"L\":-0.25,\"R\":1.00}");
        send_cmd(0, -7, "{\"T\":1,\"L\":0.00,\"R\":-0.07}");
        send_cmd(255, -256, "{\"T\":1,\"L\":1.00,\"R\":-1.00}");
        send_cmd(101, -101, "{\"T\":1,\"L\":1.00,\"R\":-1.00}");
        send_cmd(100, -100, "{\"T\":1,\"L\":1.00,\"R\":-1.00}");
        send_cmd(99, -1, "{\"T\":1,\"L\":0.99,\"R\":-0.01}");
        wait_idle(200);

        stall_cnt = 0;
        bp_mode   = 1'b1;
        send_cmd(-125, 37, "{\"T\":1,\"L\":-1.00,\"R\":0.37}");
        repeat (5) @(posedge clk);
        #1;
        chk("busy_cmd_ready", 32'(cmd_ready), 32'd0);
        left      = 9'sd77;
        right     = 9'sd77;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_idle(300);
        bp_mode = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        chk("no_queued_cmd", 32'(out_valid), 32'd0);

        send_cmd(-25, 100, "{\"T\":1,\"L\":-0.25,\"R\":1.00}");
        n = 0;
        while (rx_cnt < 12 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reached_byte12", 32'(rx_cnt >= 12), 32'd1);
        rst = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_out_last", 32'(out_last), 32'd0);
        chk("abort_out_data", 32'(out_data), 32'h00);
        @(posedge clk); #1;
        rst = 1'b1;
        send_cmd(50, -50, "{\"T\":1,\"L\":0.50,\"R\":-0.50}");
        wait_idle(200);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
